ssio_in_delay_cal: RTL



---
 rtl/ssio_cal_pkg.sv | 20 ++
 rtl/ssio_cal_window_track.sv | 77 +++++++
 rtl/ssio_in_delay_cal.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ssio_cal_pkg.sv
// Shared types and constants for the SSIO input delay calibration slice.
// FSM encoding, tap width default and PHY training-pattern constants.
package ssio_cal_pkg;

  localparam int TAP_BITS_DEF = 5;

  localparam logic [3:0] RGMII_IDLE_NIBBLE = 4'h0;
  localparam logic       RGMII_IDLE_CTL    = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_SET,
    ST_FIN
  } cal_state_e;

endpackage

// File: rtl/ssio_cal_window_track.sv
// Tracks the open passing run and the best (longest, earliest) window.
// Ports: clr_i/eval_i/pass_i/last_i/tap_i in; next-state best window out.
module ssio_cal_window_track
  import ssio_cal_pkg::*;
#(
  parameter int TAP_BITS = TAP_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                eval_i,
  input  logic                pass_i,
  input  logic                last_i,
  input  logic [TAP_BITS-1:0] tap_i,
  output logic [TAP_BITS-1:0] best_start_o,
  output logic [TAP_BITS:0]   best_len_o
);

  localparam int LW = TAP_BITS + 1;

  logic [TAP_BITS-1:0] run_start_q, run_start_d;
  logic [LW-1:0]       run_len_q, run_len_d;
  logic [TAP_BITS-1:0] best_start_q, best_start_d;
  logic [LW-1:0]       best_len_q, best_len_d;
  logic [TAP_BITS-1:0] start_acc;
  logic [LW-1:0]       len_acc;

  always_comb begin
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    start_acc    = run_start_q;
    len_acc      = run_len_q;
    if (clr_i) begin
      run_start_d  = '0;
      run_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (eval_i) begin
      if (pass_i) begin
        if (run_len_q == '0) start_acc = tap_i;
        len_acc = run_len_q + LW'(1);
      end
      run_start_d = start_acc;
      run_len_d   = len_acc;
      // a pass on the last tap joins the run before it closes;
      // strict > keeps the earliest of equal windows
      if (!pass_i || last_i) begin
        if (len_acc > best_len_q) begin
          best_start_d = start_acc;
          best_len_d   = len_acc;
        end
        run_len_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  // next-state view so the final tap is ready as the sweep ends
  assign best_start_o = best_start_d;
  assign best_len_o   = best_len_d;

endmodule

// File: rtl/ssio_in_delay_cal.sv
// Sweeps all input delay taps, scores each against a training pattern,
// then loads the centre of the longest passing window.
// Ports: clk/rst, start, pattern, data_in/data_valid in;
// delay_ld/delay_value, busy, done, locked, error, window_len out.
module ssio_in_delay_cal
  import ssio_cal_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int TAP_BITS      = TAP_BITS_DEF,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_COUNT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    pattern,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                data_valid,
  output logic                delay_ld,
  output logic [TAP_BITS-1:0] delay_value,
  output logic                busy,
  output logic                done,
  output logic                locked,
  output logic                error,
  output logic [TAP_BITS:0]   window_len
);

  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam int BCW = $clog2(SAMPLE_COUNT + 1);

  cal_state_e          state_q;
  logic [TAP_BITS-1:0] tap_q;
  logic [SCW-1:0]      set_cnt_q;
  logic [BCW-1:0]      beat_cnt_q;
  logic                fail_q;
  logic                delay_ld_q;
  logic [TAP_BITS-1:0] delay_value_q;
  logic                busy_q;
  logic                done_q;
  logic                locked_q;
  logic                error_q;
  logic [TAP_BITS:0]   window_len_q;

  logic                clr;
  logic                eval;
  logic                last_tap;
  logic [TAP_BITS-1:0] best_start;
  logic [TAP_BITS:0]   best_len;
  logic [TAP_BITS-1:0] centre;

  assign clr      = (state_q == ST_IDLE) && start;
  assign eval     = (state_q == ST_EVAL);
  assign last_tap = &tap_q;
  assign centre   = best_start + best_len[TAP_BITS:1];

  ssio_cal_window_track #(
    .TAP_BITS(TAP_BITS)
  ) u_track (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .eval_i      (eval),
    .pass_i      (!fail_q),
    .last_i      (last_tap),
    .tap_i       (tap_q),
    .best_start_o(best_start),
    .best_len_o  (best_len)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tap_q         <= '0;
      set_cnt_q     <= '0;
      beat_cnt_q    <= '0;
      fail_q        <= 1'b0;
      delay_ld_q    <= 1'b0;
      delay_value_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      locked_q      <= 1'b0;
      error_q       <= 1'b0;
      window_len_q  <= '0;
    end else begin
      delay_ld_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q       <= ST_LOAD;
            tap_q         <= '0;
            busy_q        <= 1'b1;
            locked_q      <= 1'b0;
            error_q       <= 1'b0;
            window_len_q  <= '0;
            delay_ld_q    <= 1'b1;
            delay_value_q <= '0;
          end
        end
        ST_LOAD: begin
          set_cnt_q  <= '0;
          beat_cnt_q <= '0;
          fail_q     <= 1'b0;
          state_q    <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (set_cnt_q == SCW'(SETTLE_CYCLES - 1)) begin
            state_q <= ST_SAMPLE;
          end else begin
            set_cnt_q <= set_cnt_q + SCW'(1);
          end
        end
        ST_SAMPLE: begin
          if (data_valid) begin
            if (data_in != pattern) fail_q <= 1'b1;
            if (beat_cnt_q == BCW'(SAMPLE_COUNT - 1)) begin
              state_q <= ST_EVAL;
            end else begin
              beat_cnt_q <= beat_cnt_q + BCW'(1);
            end
          end
        end
        ST_EVAL: begin
          delay_ld_q <= 1'b1;
          if (last_tap) begin
            state_q      <= ST_SET;
            window_len_q <= best_len;
            if (best_len == '0) begin
              error_q       <= 1'b1;
              delay_value_q <= '0;
            end else begin
              locked_q      <= 1'b1;
              delay_value_q <= centre;
            end
          end else begin
            state_q       <= ST_LOAD;
            tap_q         <= tap_q + TAP_BITS'(1);
            delay_value_q <= tap_q + TAP_BITS'(1);
          end
        end
        ST_SET: begin
          done_q  <= 1'b1;
          state_q <= ST_FIN;
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign delay_ld    = delay_ld_q;
  assign delay_value = delay_value_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign locked      = locked_q;
  assign error       = error_q;
  assign window_len  = window_len_q;

endmodule
